// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: sizing, FSM states and
// the Gray-to-binary helper also used by the read-side controller.
package fifo_wr_arbiter_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int PTR_WIDTH  = 3;
  localparam int PKT_MAX    = 4;

  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PKT_MAX + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the packet sources / FIFO pointer logic (master) and the
// write-port arbiter (slave).
interface fifo_wr_arbiter_if;
  import fifo_wr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic [PTR_WIDTH:0]            b_wptr;
  logic [PTR_WIDTH:0]            g_rptr_sync;
  logic                          err_clr;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [NUM_REQ-1:0]            grant;
  logic [SRC_W-1:0]              wr_src;
  logic                          busy;
  logic                          pkt_err;

  modport master (
    output req_valid, req_data, req_last, full, b_wptr, g_rptr_sync, err_clr,
    input  req_ready, wr_en, wr_data, grant, wr_src, busy, pkt_err
  );

  modport slave (
    input  req_valid, req_data, req_last, full, b_wptr, g_rptr_sync, err_clr,
    output req_ready, wr_en, wr_data, grant, wr_src, busy, pkt_err
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the rr
// pointer, scanning cyclically.
module fifo_wr_arbiter_rr #(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_rr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_any
);

  localparam int SUM_W = SRC_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [SRC_W-1:0] w_k;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_rr} + SUM_W'(i);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_k = w_sum[SRC_W-1:0];
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port among packet sources; a grant is held for a
// whole packet and only issued when a worst-case packet fits.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate when any source is valid and PKT_MAX words fit
// ST_BURST | owner's words pass to the FIFO until last or PKT_MAX words
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
(
  input logic               wr_clk,
  input logic               wr_rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [SRC_W-1:0]     r_wr_src;
  logic [SRC_W-1:0]     r_rr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_pkt_err;

  logic [PTR_WIDTH:0]   w_rptr_bin;
  logic [PTR_WIDTH:0]   w_used;
  logic                 w_fits;
  logic [NUM_REQ-1:0]   w_arb_grant;
  logic [SRC_W-1:0]     w_arb_idx;
  logic                 w_any;
  logic                 w_wr_en;
  logic                 w_last;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  assign w_rptr_bin = gray2bin(bus.g_rptr_sync);
  assign w_used     = bus.b_wptr - w_rptr_bin;
  // free >= PKT_MAX, rearranged so the compare stays unsigned
  assign w_fits     = (w_used <= (PTR_WIDTH+1)'(DEPTH - PKT_MAX));

  fifo_wr_arbiter_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_rr    (r_rr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_any)
  );

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
    assign w_words[k] = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_wr_en = r_busy & ~bus.full & (|(bus.req_valid & r_grant));
  assign w_last  = |(bus.req_last & r_grant);

  assign bus.wr_en     = w_wr_en;
  assign bus.wr_data   = w_wr_en ? w_words[r_wr_src] : '0;
  assign bus.req_ready = (r_busy & ~bus.full) ? r_grant : '0;
  assign bus.grant     = r_grant;
  assign bus.wr_src    = r_wr_src;
  assign bus.busy      = r_busy;
  assign bus.pkt_err   = r_pkt_err;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_wr_src  <= '0;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_pkt_err <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_pkt_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any && w_fits) begin
            r_grant  <= w_arb_grant;
            r_wr_src <= w_arb_idx;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_wr_en) begin
            if (w_last || r_cnt == CNT_W'(PKT_MAX - 1)) begin
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_grant  <= '0;
              r_wr_src <= '0;
              r_cnt    <= '0;
              r_rr     <= (r_wr_src == SRC_W'(NUM_REQ - 1)) ? '0 : r_wr_src + 1'b1;
              // an overlong packet is cut here; the error write wins over a clear
              if (!w_last) begin
                r_pkt_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
